// File: rtl/ef_smsdac_rx_if.sv
// Segment-code input and windowed-sum output bundle of the sigma-delta DAC loopback receiver.
interface ef_smsdac_rx_if #(
  parameter int DEC_LOG2 = 4
);
  logic                       en;
  logic [1:0]                 d_in_3;
  logic [1:0]                 d_in_2;
  logic [1:0]                 d_in_1;
  logic [1:0]                 d_in_0;
  logic signed [4+DEC_LOG2:0] sum_out;
  logic                       sum_valid;
  logic                       sum_ready;
  logic                       overrun;
  logic [7:0]                 err_cnt;

  modport master (
    output en, d_in_3, d_in_2, d_in_1, d_in_0, sum_ready,
    input  sum_out, sum_valid, overrun, err_cnt
  );

  modport slave (
    input  en, d_in_3, d_in_2, d_in_1, d_in_0, sum_ready,
    output sum_out, sum_valid, overrun, err_cnt
  );
endinterface

// File: rtl/ef_smsdac_rx.sv
// Rebuilds the signed DAC level from four 3-level segment codes and boxcar-decimates it by 2^DEC_LOG2.
// Latency: 2 cycles from the last sample of a window to sum_valid; one sample per cycle.
// Backpressure: none upstream; an unaccepted result is overwritten by the next dump and flags overrun.
module ef_smsdac_rx #(
  parameter int DEC_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  ef_smsdac_rx_if.slave  rx
);

  localparam int                    W        = 5 + DEC_LOG2;
  localparam logic [DEC_LOG2-1:0]   CNT_LAST = '1;
  localparam logic [DEC_LOG2-1:0]   CNT_ONE  = 1;

  function automatic logic signed [4:0] seg_level(input logic [1:0] code);
    logic signed [4:0] lvl;
    case (code)
      2'b10:   lvl = 5'sd1;
      2'b01:   lvl = -5'sd1;
      default: lvl = 5'sd0;
    endcase
    return lvl;
  endfunction

  // S1: raw codes and valid
  logic [1:0] c3_q, c2_q, c1_q, c0_q;
  logic       s1_vld_q;

  // S2: decoded level
  logic signed [4:0] s2_lvl_q;
  logic              s2_vld_q;
  logic              s2_ill_q;

  // S3: accumulator and output holding register
  logic signed [W-1:0]  acc_q, acc_d;
  logic [DEC_LOG2-1:0]  cnt_q, cnt_d;
  logic signed [W-1:0]  sum_q, sum_d;
  logic                 sum_vld_q, sum_vld_d;
  logic                 ovr_q, ovr_d;
  logic [7:0]           err_q, err_d;

  logic signed [4:0]    lvl_d;
  logic                 ill_d;
  logic signed [W-1:0]  acc_sum;
  logic                 dump;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      c3_q     <= '0;
      c2_q     <= '0;
      c1_q     <= '0;
      c0_q     <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      c3_q     <= rx.d_in_3;
      c2_q     <= rx.d_in_2;
      c1_q     <= rx.d_in_1;
      c0_q     <= rx.d_in_0;
      s1_vld_q <= rx.en;
    end
  end

  always_comb begin
    lvl_d = (seg_level(c3_q) <<< 3) + (seg_level(c2_q) <<< 2)
          + (seg_level(c1_q) <<< 1) +  seg_level(c0_q);
    ill_d = (c3_q == 2'b11) || (c2_q == 2'b11) || (c1_q == 2'b11) || (c0_q == 2'b11);
  end

  // en low flushes S1 contents instead of letting them advance
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s2_lvl_q <= '0;
      s2_vld_q <= 1'b0;
      s2_ill_q <= 1'b0;
    end else if (!rx.en) begin
      s2_vld_q <= 1'b0;
      s2_ill_q <= 1'b0;
    end else begin
      s2_lvl_q <= lvl_d;
      s2_vld_q <= s1_vld_q;
      s2_ill_q <= ill_d;
    end
  end

  assign acc_sum = acc_q + W'(s2_lvl_q);
  assign dump    = s2_vld_q && (cnt_q == CNT_LAST);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    sum_vld_d = sum_vld_q;
    ovr_d     = ovr_q;
    err_d     = err_q;
    if (!rx.en) begin
      acc_d     = '0;
      cnt_d     = '0;
      sum_vld_d = 1'b0;
      ovr_d     = 1'b0;
    end else begin
      if (dump) begin
        acc_d     = '0;
        cnt_d     = '0;
        sum_d     = acc_sum;
        sum_vld_d = 1'b1;
        if (sum_vld_q && !rx.sum_ready) begin
          ovr_d = 1'b1;
        end
      end else begin
        if (s2_vld_q) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CNT_ONE;
        end
        if (sum_vld_q && rx.sum_ready) begin
          sum_vld_d = 1'b0;
        end
      end
      if (s2_vld_q && s2_ill_q && (err_q != 8'hFF)) begin
        err_d = err_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      ovr_q     <= ovr_d;
      err_q     <= err_d;
    end
  end

  assign rx.sum_out   = sum_q;
  assign rx.sum_valid = sum_vld_q;
  assign rx.overrun   = ovr_q;
  assign rx.err_cnt   = err_q;

endmodule

// File: tb/tb_ef_smsdac_rx.sv
// Directed bench for ef_smsdac_rx with DEC_LOG2 = 4 (N = 16).
module tb_ef_smsdac_rx;

  localparam int DL = 4;

  logic clk = 1'b0;
  logic rst_b;
  int   n_vec = 0;
  int   n_err = 0;

  ef_smsdac_rx_if #(.DEC_LOG2(DL)) rx_if ();

  ef_smsdac_rx #(.DEC_LOG2(DL)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .rx    (rx_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_codes(input logic [1:0] c3, input logic [1:0] c2,
                           input logic [1:0] c1, input logic [1:0] c0);
    rx_if.d_in_3 = c3;
    rx_if.d_in_2 = c2;
    rx_if.d_in_1 = c1;
    rx_if.d_in_0 = c0;
  endtask

  task automatic flush();
    rx_if.en = 1'b0;
    tick();
  endtask

  initial begin
    rst_b           = 1'b0;
    rx_if.en        = 1'b0;
    rx_if.sum_ready = 1'b0;
    set_codes(2'b00, 2'b00, 2'b00, 2'b00);
    #2;
    chk("rst_sum",   32'($signed(rx_if.sum_out)), 0);
    chk("rst_vld",   32'(rx_if.sum_valid), 0);
    chk("rst_ovr",   32'(rx_if.overrun), 0);
    chk("rst_err",   32'(rx_if.err_cnt), 0);
    #20;
    rst_b = 1'b1;
    tick();

    // all +1 codes, consumer always ready: pulses at 17, 33, 49
    set_codes(2'b10, 2'b10, 2'b10, 2'b10);
    rx_if.sum_ready = 1'b1;
    rx_if.en        = 1'b1;
    for (int e = 0; e <= 49; e++) begin
      tick();
      chk("t1_vld", 32'(rx_if.sum_valid), 32'(e == 17 || e == 33 || e == 49));
      if (e == 17 || e == 33 || e == 49) begin
        chk("t1_sum", 32'($signed(rx_if.sum_out)), 240);
        chk("t1_ovr", 32'(rx_if.overrun), 0);
      end
    end

    // alternating MSB segment cancels within each window
    flush();
    set_codes(2'b10, 2'b00, 2'b00, 2'b00);
    rx_if.en = 1'b1;
    for (int e = 0; e <= 33; e++) begin
      tick();
      if (e == 17 || e == 33) begin
        chk("t2_alt_vld", 32'(rx_if.sum_valid), 1);
        chk("t2_alt_sum", 32'($signed(rx_if.sum_out)), 0);
      end
      rx_if.d_in_3 = ((e + 1) % 2 == 0) ? 2'b10 : 2'b01;
    end
    flush();
    set_codes(2'b01, 2'b01, 2'b01, 2'b01);
    rx_if.en = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      tick();
    end
    chk("t2_neg_vld", 32'(rx_if.sum_valid), 1);
    chk("t2_neg_raw", {23'b0, rx_if.sum_out}, 32'h110);
    chk("t2_neg_sum", 32'($signed(rx_if.sum_out)), -240);

    // consumer stalled: hold, overwrite with overrun, then drain
    flush();
    set_codes(2'b10, 2'b10, 2'b10, 2'b10);
    rx_if.sum_ready = 1'b0;
    rx_if.en        = 1'b1;
    for (int e = 0; e <= 49; e++) begin
      tick();
      if (e == 16) chk("t3_vld16", 32'(rx_if.sum_valid), 0);
      if (e == 17 || e == 25 || e == 32) begin
        chk("t3_hold_vld", 32'(rx_if.sum_valid), 1);
        chk("t3_hold_sum", 32'($signed(rx_if.sum_out)), 240);
        chk("t3_hold_ovr", 32'(rx_if.overrun), 0);
      end
      if (e == 33 || e == 39) begin
        chk("t3_ow_vld", 32'(rx_if.sum_valid), 1);
        chk("t3_ow_sum", 32'($signed(rx_if.sum_out)), 240);
        chk("t3_ow_ovr", 32'(rx_if.overrun), 1);
      end
      if (e == 40) begin
        chk("t3_drain_vld", 32'(rx_if.sum_valid), 0);
        chk("t3_drain_ovr", 32'(rx_if.overrun), 1);
      end
      if (e == 49) begin
        chk("t3_next_vld", 32'(rx_if.sum_valid), 1);
        chk("t3_next_ovr", 32'(rx_if.overrun), 1);
      end
      if (e == 39) rx_if.sum_ready = 1'b1;
    end
    flush();
    chk("t3_clr_vld", 32'(rx_if.sum_valid), 0);
    chk("t3_clr_ovr", 32'(rx_if.overrun), 0);
    chk("t3_clr_sum", 32'($signed(rx_if.sum_out)), 240);

    // illegal LSB code decodes to 0; error count saturates
    set_codes(2'b10, 2'b00, 2'b00, 2'b11);
    rx_if.en = 1'b1;
    for (int e = 0; e <= 299; e++) begin
      tick();
      if (e == 17 || e == 33) begin
        chk("t4_vld", 32'(rx_if.sum_valid), 1);
        chk("t4_sum", 32'($signed(rx_if.sum_out)), 128);
      end
      if (e == 1)   chk("t4_err1",   32'(rx_if.err_cnt), 0);
      if (e == 2)   chk("t4_err2",   32'(rx_if.err_cnt), 1);
      if (e == 100) chk("t4_err100", 32'(rx_if.err_cnt), 99);
      if (e == 255) chk("t4_err255", 32'(rx_if.err_cnt), 254);
      if (e == 256) chk("t4_err256", 32'(rx_if.err_cnt), 255);
      if (e == 299) chk("t4_err299", 32'(rx_if.err_cnt), 255);
    end
    flush();
    chk("t4_err_hold", 32'(rx_if.err_cnt), 255);

    // en dropped at edge 10: partial window discarded
    set_codes(2'b10, 2'b10, 2'b10, 2'b10);
    rx_if.en = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
    end
    flush();
    chk("t5_drop_vld", 32'(rx_if.sum_valid), 0);
    chk("t5_drop_ovr", 32'(rx_if.overrun), 0);
    set_codes(2'b00, 2'b00, 2'b00, 2'b10);
    rx_if.en = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      tick();
      chk("t5_vld", 32'(rx_if.sum_valid), 32'(e == 17));
    end
    chk("t5_sum", 32'($signed(rx_if.sum_out)), 16);

    // async reset while a result is pending
    flush();
    set_codes(2'b10, 2'b10, 2'b10, 2'b10);
    rx_if.sum_ready = 1'b0;
    rx_if.en        = 1'b1;
    for (int e = 0; e <= 19; e++) begin
      tick();
    end
    chk("t6_pre_vld", 32'(rx_if.sum_valid), 1);
    #3;
    rst_b = 1'b0;
    #1;
    chk("t6_rst_sum", 32'($signed(rx_if.sum_out)), 0);
    chk("t6_rst_vld", 32'(rx_if.sum_valid), 0);
    chk("t6_rst_ovr", 32'(rx_if.overrun), 0);
    chk("t6_rst_err", 32'(rx_if.err_cnt), 0);
    #2;
    rst_b = 1'b1;
    set_codes(2'b00, 2'b00, 2'b00, 2'b01);
    rx_if.sum_ready = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      tick();
      if (e == 16) chk("t6_vld16", 32'(rx_if.sum_valid), 0);
    end
    chk("t6_post_vld", 32'(rx_if.sum_valid), 1);
    chk("t6_post_sum", 32'($signed(rx_if.sum_out)), -16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
